// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter and the frame checker that
// consumes its output: state encodings, the line idle level, and a helper
// for sizing counters.
package uart_tx_pkg;

    localparam int UART_STATE_W = 3;

    typedef enum logic [UART_STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic UART_IDLE_LVL = 1'b1;

    // Width of a counter holding 0..n-1. A one-state counter still needs one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period tick generator. It counts 0..CLKS_PER_BIT-1 and wraps. bit_end
// marks the last clk of the current bit. clear restarts the count so that each
// state begins on a fresh bit period.
module uart_baud_gen
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int             CW   = cnt_w(CLKS_PER_BIT);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_end = (cnt_q == LAST);

    // Next count: restart on clear or at the end of a bit, otherwise advance.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || bit_end) cnt_d = '0;
        else                  cnt_d = cnt_q + 1'b1;
    end

    // Tick counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx.sv
// UART serializer. It accepts a word over a valid/ready handshake and drives
// the line with a start bit (0), then DATA_BITS data bits LSB first, then
// STOP_BITS stop bits (1). The line idles high.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bits.
// The line output is registered. The first start-bit cycle shows on the line in
// the cycle right after the accepting edge. A word accepted during the last
// stop cycle starts the next frame with no idle gap.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 signal,
    output logic                 busy
);

    localparam int            BW        = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 signal_q, signal_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    logic bit_end;
    logic clear;
    logic stop_last;
    logic accept;

    // The tick count restarts on every state change. While idle the count is
    // held at zero, so that a new frame always starts on a full bit period.
    assign clear = (state_d != state_q) || (state_q == ST_IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .bit_end (bit_end)
    );

    assign stop_last = (state_q == ST_STOP) && bit_end && (bit_cnt_q == LAST_STOP);
    assign tx_ready  = (state_q == ST_IDLE) || stop_last;
    assign accept    = tx_valid && tx_ready;
    assign busy      = (state_q != ST_IDLE);
    assign signal    = signal_q;

    // Next-state logic: frame sequencing, bit counting, loading and shifting
    // the data word.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_START;
                    bit_cnt_d = '0;
                    shreg_d   = tx_data;
`ifdef UART_TX_PARITY_EN
                    par_d     = ^tx_data;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d   = ST_STOP;
                    bit_cnt_d = '0;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        if (accept) begin
                            state_d = ST_START;
                            shreg_d = tx_data;
`ifdef UART_TX_PARITY_EN
                            par_d   = ^tx_data;
`endif
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    // Line level for the next cycle. It is taken from the next state, so the
    // registered output lines up with state_q without a cycle of lag.
    always_comb begin
        signal_d = UART_IDLE_LVL;
        case (state_d)
            ST_START: signal_d = 1'b0;
            ST_DATA:  signal_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: signal_d = par_q;
`endif
            default:  signal_d = UART_IDLE_LVL;
        endcase
    end

    // State, counters, data word and line register. Reset returns the line
    // high at once and discards any partial frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            signal_q  <= UART_IDLE_LVL;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            signal_q  <= signal_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule
